// File: rtl/delay_pipe_ctrl.sv
// Issue/credit controller for a fixed-latency delay-line datapath.
// Frames of FRAME_LEN beats are issued under a credit limit, and a valid/last pipe tracks them to the output.
//
// state | meaning
// IDLE  | waiting for start; outstanding credits may still be returning
// RUN   | accepting beats while credits are available
// DRAIN | frame fully issued; waiting for credits and the pipe to empty
module delay_pipe_ctrl #(
    parameter int LATENCY   = 2,
    parameter int CREDITS   = 4,
    parameter int FRAME_LEN = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic s_valid,
    output logic s_ready,
    output logic dp_en,
    output logic dp_valid,
    output logic dp_last,
    input  logic credit_ret,
    output logic busy,
    output logic done,
    output logic err
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [3:0]  CRED_MAX  = 4'(CREDITS);
    localparam logic [15:0] LAST_BEAT = 16'(FRAME_LEN - 1);

    state_t      state, state_nxt;
    logic [3:0]  outstanding;
    logic [15:0] beat_cnt;
    logic        issue_last;
    logic        cred_ok;
    logic        pipe_busy;

    assign s_ready    = (state == RUN) && (outstanding < CRED_MAX);
    assign dp_en      = s_valid && s_ready;
    assign issue_last = dp_en && (beat_cnt == LAST_BEAT);
    assign cred_ok    = credit_ret && (outstanding != 4'd0);
    assign busy       = (state != IDLE);

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (issue_last) state_nxt = DRAIN;
            DRAIN: begin
                if ((outstanding == 4'd0) && !pipe_busy) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A credit with nothing outstanding is ignored for counting and flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= 4'd0;
            beat_cnt    <= 16'd0;
            err         <= 1'b0;
        end else begin
            if ((state == IDLE) && start) begin
                beat_cnt <= 16'd0;
            end else if (dp_en) begin
                beat_cnt <= beat_cnt + 16'd1;
            end
            if (dp_en && !cred_ok) begin
                outstanding <= outstanding + 4'd1;
            end else if (!dp_en && cred_ok) begin
                outstanding <= outstanding - 4'd1;
            end
            if (credit_ret && (outstanding == 4'd0)) begin
                err <= 1'b1;
            end
        end
    end

    generate
        if (LATENCY == 0) begin : g_comb
            assign dp_valid  = dp_en;
            assign dp_last   = issue_last;
            assign pipe_busy = 1'b0;
        end else begin : g_pipe
            logic [LATENCY-1:0] vld_pipe;
            logic [LATENCY-1:0] last_pipe;

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_pipe  <= '0;
                    last_pipe <= '0;
                end else begin
                    vld_pipe[0]  <= dp_en;
                    last_pipe[0] <= issue_last;
                    for (int i = 1; i < LATENCY; i++) begin
                        vld_pipe[i]  <= vld_pipe[i-1];
                        last_pipe[i] <= last_pipe[i-1];
                    end
                end
            end

            assign dp_valid  = vld_pipe[LATENCY-1];
            assign dp_last   = last_pipe[LATENCY-1];
            assign pipe_busy = |vld_pipe;
        end
    endgenerate

endmodule
